branch_resolve_unit: RTL and testbench
======================================

Name: branch_resolve_unit

Overview:
- Execute-side partner of the 2-bit branch predictor.
- Holds in-flight predictions in order and checks each against the real outcome when the branch executes.
- Drives the predictor's update inputs (branch, branch_taken, pc).
- Raises a one-cycle flush with a redirect PC on a mispredict, and keeps resolution/mispredict statistics.

Parameters:
- DEPTH, 4, number of in-flight prediction entries (power of 2)
- PTR_BITS, 2, log2(DEPTH)
- CNT_WIDTH, 16, width of statistics counters

Ports:
- clk  input  1  clock
- rst  input  1  reset, asynchronous, active-high
- pred_valid  input  1  fetch issues a predicted branch this cycle
- pred_pc  input  32  PC of predicted branch
- pred_taken  input  1  predicted direction
- pred_target  input  32  predicted target (meaningful when pred_taken=1)
- pred_ready  output  1  queue can accept an entry
- res_valid  input  1  execute resolves the oldest in-flight branch
- res_taken  input  1  actual direction
- res_target  input  32  actual target
- upd_branch  output  1  predictor update strobe (to predictor branch)
- upd_pc  output  32  PC for predictor index
- upd_taken  output  1  actual outcome (to predictor branch_taken)
- flush  output  1  mispredict flush pulse
- redirect_pc  output  32  correct fetch PC, valid while flush=1
- branch_count  output  CNT_WIDTH  resolved branches
- mispredict_count  output  CNT_WIDTH  mispredicted branches

Behaviour:
- Reset values: all outputs 0 except pred_ready=1; queue empty; head/tail/count 0; FSM=RUN.
- Queue is a circular FIFO of {pc, taken, target}. Pointers wrap modulo DEPTH. Count is 0..DEPTH.
- pred_ready = (count < DEPTH) && (state==RUN). It is computed from registered state only, so a pop in the same cycle does not free a slot.
- Push: pred_valid && pred_ready writes the tail entry.
- Pop: res_valid && count>0 pops the head entry.
- Push and pop in the same cycle: count is unchanged.
- res_valid with an empty queue: ignored. No update, no counter change.
- Mispredict: (head.taken != res_taken) || (res_taken && head.target != res_target).
- Latency: 1 cycle. The cycle after a pop, upd_branch=1, upd_pc=head.pc, upd_taken=res_taken. These are 1-cycle pulses; upd_pc and upd_taken hold their last value otherwise.
- FSM:
  - RUN -> FLUSH on a popping resolution that mispredicts.
  - FLUSH -> RUN unconditionally after 1 cycle.
- In FLUSH:
  - flush=1.
  - redirect_pc = res_taken ? res_target : head.pc+4 (32-bit wrap). Captured at the mispredict edge.
- Mispredict edge:
  - The whole queue is cleared (count=0, head=tail), because all younger entries are wrong-path.
  - A push offered in that same cycle is dropped.
  - pred_valid is also ignored for the whole FLUSH cycle.
- Resolution in the FLUSH cycle: queue is empty, so it is ignored.
- Counters: branch_count +1 per pop; mispredict_count +1 per mispredicting pop. Both saturate at all-ones.
- Reset mid-operation clears the queue, FSM and counters immediately (async), including an in-progress flush.

Optional Feature:
- BRU_UNDERFLOW_ERR_EN defined:
  - Adds output port err (1 bit, reset 0).
  - err is sticky-set the cycle after res_valid with an empty queue, outside FLUSH.
  - err is cleared only by rst.
- Undefined: no err port; underflow is silently ignored.

Test Plan:
- Push pc=0x100 taken=0, then resolve res_taken=0 -> next cycle upd_branch=1, upd_pc=0x100, upd_taken=0; flush=0; branch_count=1, mispredict_count=0.
- Push pc=0x200 taken=0, resolve res_taken=1 res_target=0x400 -> flush=1 for exactly 1 cycle, redirect_pc=0x400, mispredict_count=1, queue empty.
- Push pc=0x300 taken=1 target=0x500, resolve taken=1 target=0x504 -> flush=1, redirect_pc=0x504. Separately, predicted taken but resolved not taken -> redirect_pc=0x304.
- Push 4 entries (0x10,0x14,0x18,0x1C) -> pred_ready=0. Pop+push in the same cycle -> the push is not accepted. Pop all -> upd_pc order 0x10,0x14,0x18,0x1C.
- Mispredict on 0x10 with 3 younger entries queued and pred_valid=1 on the same edge -> count=0, no upd for younger entries, pred_ready=0 during flush then 1.
- res_valid with an empty queue -> no upd, counters unchanged; with BRU_UNDERFLOW_ERR_EN, err=1 until rst. Assert rst mid-flush -> flush=0, counters=0 immediately.

Source files
------------

// File: rtl/branch_resolve_unit.sv
// ---------------------------------------------------------------------------
// branch_resolve_unit
//   Execute-side partner of the 2-bit branch predictor. In-flight predictions
//   are held in order in a small circular queue. When execute resolves the
//   oldest branch, the prediction is checked against the real outcome. The
//   predictor is updated one cycle later. A mispredict raises a one-cycle
//   flush with the correct fetch PC and discards every younger entry.
//
//   Optional feature macro: BRU_UNDERFLOW_ERR_EN
//     When defined, adds a sticky 'err' output. It is set the cycle after a
//     resolution arrives with an empty queue outside FLUSH. Only rst clears it.
//
// Ports
//   clk, rst            clock, asynchronous active-high reset
//   pred_valid/pc/taken/target   prediction issued by fetch
//   pred_ready          queue can accept a prediction
//   res_valid/taken/target       resolution of the oldest in-flight branch
//   upd_branch/pc/taken predictor update (1-cycle strobe, pc/taken held)
//   flush, redirect_pc  mispredict flush pulse and correct fetch PC
//   branch_count        resolved branches (saturating)
//   mispredict_count    mispredicted branches (saturating)
//   err                 underflow error, only with BRU_UNDERFLOW_ERR_EN
//
// state   | meaning
// --------+----------------------------------------------------------
// S_RUN   | normal operation, accepting predictions and resolutions
// S_FLUSH | one-cycle flush pulse, queue empty, fetch input ignored
// ---------------------------------------------------------------------------
module branch_resolve_unit #(
  parameter int DEPTH     = 4,
  parameter int PTR_BITS  = 2,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 pred_valid,
  input  logic [31:0]          pred_pc,
  input  logic                 pred_taken,
  input  logic [31:0]          pred_target,
  output logic                 pred_ready,
  input  logic                 res_valid,
  input  logic                 res_taken,
  input  logic [31:0]          res_target,
  output logic                 upd_branch,
  output logic [31:0]          upd_pc,
  output logic                 upd_taken,
  output logic                 flush,
  output logic [31:0]          redirect_pc,
  output logic [CNT_WIDTH-1:0] branch_count,
  output logic [CNT_WIDTH-1:0] mispredict_count
`ifdef BRU_UNDERFLOW_ERR_EN
  ,
  output logic                 err
`endif
);

  typedef enum logic {S_RUN, S_FLUSH} state_t;

  localparam logic [PTR_BITS:0]    FULL_CNT = DEPTH[PTR_BITS:0];
  localparam logic [PTR_BITS:0]    CNT_ONE  = 1;
  localparam logic [PTR_BITS-1:0]  PTR_ONE  = 1;
  localparam logic [CNT_WIDTH-1:0] STAT_ONE = 1;

  logic [31:0] pc_mem  [DEPTH];
  logic        tkn_mem [DEPTH];
  logic [31:0] tgt_mem [DEPTH];

  state_t                state_q;
  logic [PTR_BITS-1:0]   head_q, head_d;
  logic [PTR_BITS-1:0]   tail_q, tail_d;
  logic [PTR_BITS:0]     count_q, count_d;
  logic                  upd_branch_q;
  logic [31:0]           upd_pc_q;
  logic                  upd_taken_q;
  logic [31:0]           redirect_q;
  logic [CNT_WIDTH-1:0]  br_cnt_q;
  logic [CNT_WIDTH-1:0]  mp_cnt_q;

  logic        push, pop, mispredict;
  logic [31:0] head_pc, head_tgt;
  logic        head_tkn;

  // Ready depends only on registered state, so a same-cycle pop never frees
  // a slot for a same-cycle push.
  assign pred_ready = (count_q != FULL_CNT) && (state_q == S_RUN);
  assign push       = pred_valid && pred_ready;
  assign pop        = res_valid && (count_q != '0);

  assign head_pc  = pc_mem[head_q];
  assign head_tkn = tkn_mem[head_q];
  assign head_tgt = tgt_mem[head_q];

  // The target only matters when the branch was actually taken.
  assign mispredict = pop && ((head_tkn != res_taken) ||
                              (res_taken && (head_tgt != res_target)));

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (mispredict) begin
      // Everything younger is wrong-path; a push offered now is dropped.
      head_d  = tail_q;
      count_d = '0;
    end else begin
      if (push) tail_d = tail_q + PTR_ONE;
      if (pop)  head_d = head_q + PTR_ONE;
      if (push && !pop)      count_d = count_q + CNT_ONE;
      else if (pop && !push) count_d = count_q - CNT_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !mispredict) begin
      pc_mem[tail_q]  <= pred_pc;
      tkn_mem[tail_q] <= pred_taken;
      tgt_mem[tail_q] <= pred_target;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_RUN;
      head_q       <= '0;
      tail_q       <= '0;
      count_q      <= '0;
      upd_branch_q <= 1'b0;
      upd_pc_q     <= '0;
      upd_taken_q  <= 1'b0;
      redirect_q   <= '0;
      br_cnt_q     <= '0;
      mp_cnt_q     <= '0;
    end else begin
      head_q       <= head_d;
      tail_q       <= tail_d;
      count_q      <= count_d;
      upd_branch_q <= pop;
      if (pop) begin
        upd_pc_q    <= head_pc;
        upd_taken_q <= res_taken;
        if (br_cnt_q != '1) br_cnt_q <= br_cnt_q + STAT_ONE;
      end
      case (state_q)
        S_RUN: begin
          if (mispredict) begin
            state_q    <= S_FLUSH;
            redirect_q <= res_taken ? res_target : head_pc + 32'd4;
            if (mp_cnt_q != '1) mp_cnt_q <= mp_cnt_q + STAT_ONE;
          end
        end
        S_FLUSH: state_q <= S_RUN;
        default: state_q <= S_RUN;
      endcase
    end
  end

  assign upd_branch       = upd_branch_q;
  assign upd_pc           = upd_pc_q;
  assign upd_taken        = upd_taken_q;
  assign flush            = (state_q == S_FLUSH);
  assign redirect_pc      = redirect_q;
  assign branch_count     = br_cnt_q;
  assign mispredict_count = mp_cnt_q;

`ifdef BRU_UNDERFLOW_ERR_EN
  logic err_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q <= 1'b0;
    end else if (res_valid && (count_q == '0) && (state_q == S_RUN)) begin
      err_q <= 1'b1;
    end
  end

  assign err = err_q;
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
module tb_branch_resolve_unit;

  localparam int DEPTH = 4;
  localparam int SW    = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        pred_valid, pred_taken, res_valid, res_taken;
  logic [31:0] pred_pc, pred_target, res_target;

  logic        pred_ready, upd_branch, upd_taken, flush;
  logic [31:0] upd_pc, redirect_pc;
  logic [15:0] branch_count, mispredict_count;

  logic          s_pred_ready, s_upd_branch, s_upd_taken, s_flush;
  logic [31:0]   s_upd_pc, s_redirect_pc;
  logic [SW-1:0] s_branch_count, s_mispredict_count;
`ifdef BRU_UNDERFLOW_ERR_EN
  logic err, s_err;
`endif

  always #5 clk = ~clk;

  branch_resolve_unit #(.DEPTH(4), .PTR_BITS(2), .CNT_WIDTH(16)) u_dut (
    .clk(clk), .rst(rst),
    .pred_valid(pred_valid), .pred_pc(pred_pc), .pred_taken(pred_taken),
    .pred_target(pred_target), .pred_ready(pred_ready),
    .res_valid(res_valid), .res_taken(res_taken), .res_target(res_target),
    .upd_branch(upd_branch), .upd_pc(upd_pc), .upd_taken(upd_taken),
    .flush(flush), .redirect_pc(redirect_pc),
    .branch_count(branch_count), .mispredict_count(mispredict_count)
`ifdef BRU_UNDERFLOW_ERR_EN
    , .err(err)
`endif
  );

  // Narrow-counter instance shares all stimulus and exercises saturation.
  branch_resolve_unit #(.DEPTH(4), .PTR_BITS(2), .CNT_WIDTH(SW)) u_sat (
    .clk(clk), .rst(rst),
    .pred_valid(pred_valid), .pred_pc(pred_pc), .pred_taken(pred_taken),
    .pred_target(pred_target), .pred_ready(s_pred_ready),
    .res_valid(res_valid), .res_taken(res_taken), .res_target(res_target),
    .upd_branch(s_upd_branch), .upd_pc(s_upd_pc), .upd_taken(s_upd_taken),
    .flush(s_flush), .redirect_pc(s_redirect_pc),
    .branch_count(s_branch_count), .mispredict_count(s_mispredict_count)
`ifdef BRU_UNDERFLOW_ERR_EN
    , .err(s_err)
`endif
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural reference model ----------------
  typedef struct {
    logic [31:0] pc;
    logic        taken;
    logic [31:0] tgt;
  } ent_t;

  ent_t        mq[$];
  bit          m_flush;
  int          m_bc, m_mc;
  bit          m_ub, m_ut, m_err;
  logic [31:0] m_upc, m_redir;

  function automatic logic [31:0] sat(input int v, input int w);
    int mx;
    mx = (1 << w) - 1;
    return (v > mx) ? mx : v;
  endfunction

  task automatic model_reset();
    mq.delete();
    m_flush = 0; m_bc = 0; m_mc = 0;
    m_ub = 0; m_ut = 0; m_err = 0;
    m_upc = '0; m_redir = '0;
  endtask

  task automatic model_step();
    bit   rdy, pop, mis;
    ent_t h;
    rdy = (mq.size() < DEPTH) && !m_flush;
    pop = res_valid && (mq.size() > 0);
    mis = 0;
    if (res_valid && mq.size() == 0 && !m_flush) m_err = 1;
    m_ub = pop;
    if (pop) begin
      h     = mq.pop_front();
      m_upc = h.pc;
      m_ut  = res_taken;
      m_bc++;
      mis = (h.taken != res_taken) || (res_taken && h.tgt != res_target);
      if (mis) begin
        m_mc++;
        m_redir = res_taken ? res_target : h.pc + 32'd4;
        mq.delete();
      end
    end
    if (pred_valid && rdy && !mis) begin
      h.pc = pred_pc; h.taken = pred_taken; h.tgt = pred_target;
      mq.push_back(h);
    end
    m_flush = mis;
  endtask

  task automatic compare_all();
    bit rdy;
    rdy = (mq.size() < DEPTH) && !m_flush;
    chk("upd_branch", upd_branch, m_ub);
    chk("upd_pc", upd_pc, m_upc);
    chk("upd_taken", upd_taken, m_ut);
    chk("flush", flush, m_flush);
    chk("redirect_pc", redirect_pc, m_redir);
    chk("pred_ready", pred_ready, rdy);
    chk("branch_count", branch_count, sat(m_bc, 16));
    chk("mispredict_count", mispredict_count, sat(m_mc, 16));
    chk("sat_flush", s_flush, m_flush);
    chk("sat_branch_count", s_branch_count, sat(m_bc, SW));
    chk("sat_mispredict_count", s_mispredict_count, sat(m_mc, SW));
`ifdef BRU_UNDERFLOW_ERR_EN
    chk("err", err, m_err);
`endif
  endtask

  task automatic step(input bit pv, input logic [31:0] ppc, input bit pt,
                      input logic [31:0] ptg, input bit rv, input bit rt,
                      input logic [31:0] rtg);
    @(negedge clk);
    pred_valid = pv; pred_pc = ppc; pred_taken = pt; pred_target = ptg;
    res_valid = rv; res_taken = rt; res_target = rtg;
    @(posedge clk);
    model_step();
    #1;
    compare_all();
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    bit pv; logic [31:0] ppc; bit pt; logic [31:0] ptg;
    bit rv; bit rt; logic [31:0] rtg;
    bit e_ub; logic [31:0] e_upc; bit e_ut;
    bit e_fl; logic [31:0] e_red;
    bit e_rdy; int e_bc; int e_mc;
  } vec_t;

  vec_t tv[$];

  function automatic vec_t mk(bit pv, logic [31:0] ppc, bit pt, logic [31:0] ptg,
                              bit rv, bit rt, logic [31:0] rtg,
                              bit ub, logic [31:0] upc, bit ut, bit fl,
                              logic [31:0] red, bit rdy, int bc, int mc);
    vec_t v;
    v.pv = pv; v.ppc = ppc; v.pt = pt; v.ptg = ptg;
    v.rv = rv; v.rt = rt; v.rtg = rtg;
    v.e_ub = ub; v.e_upc = upc; v.e_ut = ut; v.e_fl = fl; v.e_red = red;
    v.e_rdy = rdy; v.e_bc = bc; v.e_mc = mc;
    return v;
  endfunction

  initial begin
    // correct not-taken
    tv.push_back(mk(1,'h100,0,0,     0,0,0,      0,0,0,       0,0,      1,0,0));
    tv.push_back(mk(0,0,0,0,         1,0,0,      1,'h100,0,   0,0,      1,1,0));
    // direction mispredict
    tv.push_back(mk(1,'h200,0,0,     0,0,0,      0,0,0,       0,0,      1,1,0));
    tv.push_back(mk(0,0,0,0,         1,1,'h400,  1,'h200,1,   1,'h400,  0,2,1));
    tv.push_back(mk(0,0,0,0,         0,0,0,      0,0,0,       0,0,      1,2,1));
    // target mispredict
    tv.push_back(mk(1,'h300,1,'h500, 0,0,0,      0,0,0,       0,0,      1,2,1));
    tv.push_back(mk(0,0,0,0,         1,1,'h504,  1,'h300,1,   1,'h504,  0,3,2));
    tv.push_back(mk(0,0,0,0,         0,0,0,      0,0,0,       0,0,      1,3,2));
    // predicted taken, resolved not taken -> fall-through
    tv.push_back(mk(1,'h300,1,'h500, 0,0,0,      0,0,0,       0,0,      1,3,2));
    tv.push_back(mk(0,0,0,0,         1,0,0,      1,'h300,0,   1,'h304,  0,4,3));
    tv.push_back(mk(0,0,0,0,         0,0,0,      0,0,0,       0,0,      1,4,3));
    // fill, pop+push while full (push refused), drain in order
    tv.push_back(mk(1,'h10,0,0,      0,0,0,      0,0,0,       0,0,      1,4,3));
    tv.push_back(mk(1,'h14,0,0,      0,0,0,      0,0,0,       0,0,      1,4,3));
    tv.push_back(mk(1,'h18,0,0,      0,0,0,      0,0,0,       0,0,      1,4,3));
    tv.push_back(mk(1,'h1C,0,0,      0,0,0,      0,0,0,       0,0,      0,4,3));
    tv.push_back(mk(1,'h20,0,0,      1,0,0,      1,'h10,0,    0,0,      1,5,3));
    tv.push_back(mk(0,0,0,0,         1,0,0,      1,'h14,0,    0,0,      1,6,3));
    tv.push_back(mk(0,0,0,0,         1,0,0,      1,'h18,0,    0,0,      1,7,3));
    tv.push_back(mk(0,0,0,0,         1,0,0,      1,'h1C,0,    0,0,      1,8,3));
    // resolution on empty queue is ignored
    tv.push_back(mk(0,0,0,0,         1,0,0,      0,0,0,       0,0,      1,8,3));
    // mispredict with younger entries and a simultaneous push
    tv.push_back(mk(1,'h10,0,0,      0,0,0,      0,0,0,       0,0,      1,8,3));
    tv.push_back(mk(1,'h14,0,0,      0,0,0,      0,0,0,       0,0,      1,8,3));
    tv.push_back(mk(1,'h18,0,0,      0,0,0,      0,0,0,       0,0,      1,8,3));
    tv.push_back(mk(1,'h1C,0,0,      0,0,0,      0,0,0,       0,0,      0,8,3));
    tv.push_back(mk(1,'h40,0,0,      1,1,'h80,   1,'h10,1,    1,'h80,   0,9,4));
    tv.push_back(mk(1,'h44,0,0,      1,0,0,      0,0,0,       0,0,      1,9,4));
    tv.push_back(mk(0,0,0,0,         1,0,0,      0,0,0,       0,0,      1,9,4));
    tv.push_back(mk(1,'h50,0,0,      0,0,0,      0,0,0,       0,0,      1,9,4));
    tv.push_back(mk(0,0,0,0,         1,0,0,      1,'h50,0,    0,0,      1,10,4));
  end

  // ---------------- main sequence ----------------
  initial begin
    bit          pv, pt, rv, rt;
    logic [31:0] ppc, ptg, rtg;

    pred_valid = 0; pred_pc = '0; pred_taken = 0; pred_target = '0;
    res_valid = 0; res_taken = 0; res_target = '0;
    rst = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    compare_all();
    chk("reset_upd_branch", upd_branch, 1'b0);
    chk("reset_pred_ready", pred_ready, 1'b1);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < tv.size(); i++) begin
      step(tv[i].pv, tv[i].ppc, tv[i].pt, tv[i].ptg, tv[i].rv, tv[i].rt, tv[i].rtg);
      chk($sformatf("tv%0d_upd_branch", i), upd_branch, tv[i].e_ub);
      if (tv[i].e_ub) begin
        chk($sformatf("tv%0d_upd_pc", i), upd_pc, tv[i].e_upc);
        chk($sformatf("tv%0d_upd_taken", i), upd_taken, tv[i].e_ut);
      end
      chk($sformatf("tv%0d_flush", i), flush, tv[i].e_fl);
      if (tv[i].e_fl) chk($sformatf("tv%0d_redirect", i), redirect_pc, tv[i].e_red);
      chk($sformatf("tv%0d_ready", i), pred_ready, tv[i].e_rdy);
      chk($sformatf("tv%0d_branch_count", i), branch_count, tv[i].e_bc);
      chk($sformatf("tv%0d_mispredict_count", i), mispredict_count, tv[i].e_mc);
    end
    chk("sat_branch_count_pinned", s_branch_count, 3'd7);
`ifdef BRU_UNDERFLOW_ERR_EN
    chk("err_sticky", err, 1'b1);
`endif

    // async reset during a flush
    step(1, 'h60, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1, 1, 'h90);
    chk("pre_rst_flush", flush, 1'b1);
    rst = 1'b1;
    #1;
    chk("rst_flush", flush, 1'b0);
    chk("rst_branch_count", branch_count, 16'd0);
    chk("rst_mispredict_count", mispredict_count, 16'd0);
    chk("rst_pred_ready", pred_ready, 1'b1);
`ifdef BRU_UNDERFLOW_ERR_EN
    chk("rst_err", err, 1'b0);
`endif
    model_reset();
    @(negedge clk);
    rst = 1'b0;

    // randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      pv  = ($urandom_range(0, 2) != 0);
      ppc = 32'($urandom_range(0, 1023)) << 2;
      pt  = $urandom_range(0, 1) != 0;
      ptg = $urandom_range(0, 1) != 0 ? 32'h1000 : 32'h1004;
      rv  = ($urandom_range(0, 2) == 0);
      if (mq.size() > 0 && $urandom_range(0, 3) != 0) begin
        rt  = mq[0].taken;
        rtg = mq[0].tgt;
      end else begin
        rt  = $urandom_range(0, 1) != 0;
        rtg = $urandom_range(0, 1) != 0 ? 32'h1000 : 32'h1004;
      end
      step(pv, ppc, pt, ptg, rv, rt, rtg);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
